// File: rtl/rtype_pkg.sv
// Shared constants for the R-type issue/writeback unit: instruction field
// positions, the R-type opcode and the ALU function codes.
package rtype_pkg;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;

  localparam int unsigned REG_AW     = 5;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam logic [5:0] FUNCT_ADD = 6'b001001;
  localparam logic [5:0] FUNCT_SUB = 6'b001010;
  localparam logic [5:0] FUNCT_SLL = 6'b100001;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  // True when an in-flight destination 'dst' is a real register that an
  // incoming source 'src' depends on. Register 0 never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/rtype_regfile.sv
// 32-entry register file: two combinational operand reads, one combinational
// debug read, one synchronous write. Register 0 always reads zero and is never
// written. A synchronous active-low reset clears every entry.
module rtype_regfile
  import rtype_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [4:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [4:0]        i_raddr_a,
  input  logic [4:0]        i_raddr_b,
  input  logic [4:0]        i_raddr_dbg,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_rdata_dbg
);

  localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

  logic [DATA_W-1:0] r_mem [32];

  // Storage: clear on reset, otherwise commit the single write port (reg 0 excluded)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= ZERO_W;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is visible only after the edge
  assign o_rdata_a   = (i_raddr_a   == 5'd0) ? ZERO_W : r_mem[i_raddr_a];
  assign o_rdata_b   = (i_raddr_b   == 5'd0) ? ZERO_W : r_mem[i_raddr_b];
  assign o_rdata_dbg = (i_raddr_dbg == 5'd0) ? ZERO_W : r_mem[i_raddr_dbg];

endmodule

// File: rtl/rtype_issue_unit.sv
// Issue/writeback side of the R-type datapath. Decodes an incoming R-type
// instruction, reads operands, registers them toward the external ALU (EX),
// then captures the ALU result and writes it back (WB).
// Build option: define RTYPE_ISSUE_FORWARD_EN to bypass the EX result into
// dependent operands; without it a dependent instruction stalls one cycle.
module rtype_issue_unit
  import rtype_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_rs_data,
  output logic [DATA_W-1:0] alu_rt_data,
  output logic [4:0]        alu_shamt,
  output logic [5:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_rd_data,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_cnt,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [DATA_W-1:0] ZERO_W  = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZER = {CNT_W{1'b0}};

  // Instruction fields
  logic [5:0] w_opcode;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [4:0] w_shamt;
  logic [5:0] w_funct;

  assign w_opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign w_rs     = instr[RS_MSB:RS_LSB];
  assign w_rt     = instr[RT_MSB:RT_LSB];
  assign w_rd     = instr[RD_MSB:RD_LSB];
  assign w_shamt  = instr[SHAMT_MSB:SHAMT_LSB];
  assign w_funct  = instr[FUNCT_MSB:FUNCT_LSB];

  logic w_is_rtype;
  assign w_is_rtype = (w_opcode == OPC_RTYPE);

  // EX stage state
  logic              r_ex_valid;
  logic [4:0]        r_ex_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [4:0]        r_shamt;
  logic [5:0]        r_funct;
  logic              r_illegal;

  // WB stage state
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [CNT_W-1:0]  r_retired;

  // Register file reads
  logic [DATA_W-1:0] w_rs_rf;
  logic [DATA_W-1:0] w_rt_rf;

  rtype_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (r_ex_valid),
    .i_waddr     (r_ex_rd),
    .i_wdata     (alu_rd_data),
    .i_raddr_a   (w_rs),
    .i_raddr_b   (w_rt),
    .i_raddr_dbg (dbg_addr),
    .o_rdata_a   (w_rs_rf),
    .o_rdata_b   (w_rt_rf),
    .o_rdata_dbg (dbg_data)
  );

  // Dependency of the incoming instruction on the one currently in EX
  logic w_rs_hit;
  logic w_rt_hit;
  assign w_rs_hit = r_ex_valid && reg_match(r_ex_rd, w_rs);
  assign w_rt_hit = r_ex_valid && reg_match(r_ex_rd, w_rt);

  logic              w_stall;
  logic [DATA_W-1:0] w_rs_op;
  logic [DATA_W-1:0] w_rt_op;

`ifdef RTYPE_ISSUE_FORWARD_EN
  // Operand select: bypass the EX result (being written this edge) into dependent sources
  always_comb begin
    w_stall = 1'b0;
    w_rs_op = w_rs_rf;
    w_rt_op = w_rt_rf;
    if (w_rs_hit) begin
      w_rs_op = alu_rd_data;
    end else begin
      w_rs_op = w_rs_rf;
    end
    if (w_rt_hit) begin
      w_rt_op = alu_rd_data;
    end else begin
      w_rt_op = w_rt_rf;
    end
  end
`else
  // Operand select: no bypass, hold off a dependent R-type instr until its source is written
  always_comb begin
    w_stall = 1'b0;
    w_rs_op = w_rs_rf;
    w_rt_op = w_rt_rf;
    if (w_is_rtype && (w_rs_hit || w_rt_hit)) begin
      w_stall = 1'b1;
    end else begin
      w_stall = 1'b0;
    end
  end
`endif

  logic w_accept;
  assign instr_ready = rst_n & ~w_stall;
  assign w_accept    = instr_valid & instr_ready;

  // EX stage: latch operands for the ALU on a legal accept, flag illegal opcodes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_rd    <= 5'd0;
      r_rs_data  <= ZERO_W;
      r_rt_data  <= ZERO_W;
      r_shamt    <= 5'd0;
      r_funct    <= 6'd0;
      r_illegal  <= 1'b0;
    end else begin
      r_ex_valid <= w_accept & w_is_rtype;
      r_illegal  <= w_accept & ~w_is_rtype;
      if (w_accept && w_is_rtype) begin
        r_ex_rd   <= w_rd;
        r_rs_data <= w_rs_op;
        r_rt_data <= w_rt_op;
        r_shamt   <= w_shamt;
        r_funct   <= w_funct;
      end
    end
  end

  // WB stage: report the ALU result of the EX instruction and count retirements
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= ZERO_W;
      r_retired  <= CNT_ZER;
    end else begin
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_data <= alu_rd_data;
        r_retired <= r_retired + CNT_ONE;
      end
    end
  end

  assign alu_rs_data = r_rs_data;
  assign alu_rt_data = r_rt_data;
  assign alu_shamt   = r_shamt;
  assign alu_funct   = r_funct;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign illegal     = r_illegal;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_rtype_issue_unit.sv
// Self-checking bench for rtype_issue_unit. Provides the external ALU and an
// instruction-level reference model (register array + one in-flight result).
// Honours RTYPE_ISSUE_FORWARD_EN the same way the design does.
module tb_rtype_issue_unit;
  import rtype_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [5:0] FUNCT_LDK = 6'b111111;  // bench ALU: result = shamt
  localparam logic [5:0] OPC_LW    = 6'b100011;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] alu_rs_data, alu_rt_data, alu_rd_data;
  logic [4:0]        alu_shamt;
  logic [5:0]        alu_funct;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              illegal;
  logic [CNT_W-1:0]  retired_cnt;
  logic [4:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rtype_issue_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_rs_data(alu_rs_data), .alu_rt_data(alu_rt_data),
    .alu_shamt(alu_shamt), .alu_funct(alu_funct), .alu_rd_data(alu_rd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
    .retired_cnt(retired_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sh, input logic [5:0] fn);
    case (fn)
      FUNCT_ADD: return a + b;
      FUNCT_SUB: return a - b;
      FUNCT_SLL: return a << sh;
      FUNCT_OR:  return a | b;
      FUNCT_LDK: return {27'd0, sh};
      default:   return 32'd0;
    endcase
  endfunction

  assign alu_rd_data = alu_f(alu_rs_data, alu_rt_data, alu_shamt, alu_funct);

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // Reference model state
  logic [31:0]      m_regs [32];
  bit               m_if_v;
  logic [4:0]       m_if_rd;
  logic [31:0]      m_if_val;
  bit               m_wb_v;
  logic [4:0]       m_wb_rd;
  logic [31:0]      m_wb_data;
  bit               m_ill;
  logic [CNT_W-1:0] m_cnt;
  logic [31:0]      m_rs_d, m_rt_d;
  logic [4:0]       m_sh;
  logic [5:0]       m_fn;
  bit               m_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_if_v = 1'b0; m_if_rd = 5'd0; m_if_val = 32'd0;
    m_wb_v = 1'b0; m_wb_rd = 5'd0; m_wb_data = 32'd0;
    m_ill = 1'b0; m_cnt = '0;
    m_rs_d = 32'd0; m_rt_d = 32'd0; m_sh = 5'd0; m_fn = 6'd0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, update model, check registered outputs
  task automatic step(input bit v, input logic [31:0] ins, input bit rstn);
    logic [5:0] op;
    logic [4:0] rs, rt, rd, sh;
    logic [5:0] fn;
    bit rdy, acc;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
    rst_n = rstn; instr_valid = v; instr = ins;
    dbg_addr = 5'($urandom_range(0, 31));
    #1;
    rdy = rstn;
`ifndef RTYPE_ISSUE_FORWARD_EN
    if (op == 6'd0 && m_if_v && m_if_rd != 5'd0 && (m_if_rd == rs || m_if_rd == rt)) rdy = 1'b0;
`endif
    check("instr_ready", {31'd0, instr_ready}, {31'd0, rdy});
    check("dbg_data", dbg_data, m_regs[dbg_addr]);
    acc = v && rdy;
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      // retire the in-flight instruction, then the new one sees the newest register values
      m_wb_v = m_if_v;
      if (m_if_v) begin
        m_wb_rd = m_if_rd; m_wb_data = m_if_val;
        if (m_if_rd != 5'd0) m_regs[m_if_rd] = m_if_val;
        m_cnt = m_cnt + 1'b1;
      end
      m_ill  = acc && (op != 6'd0);
      m_if_v = acc && (op == 6'd0);
      if (m_if_v) begin
        m_rs_d = m_regs[rs]; m_rt_d = m_regs[rt]; m_sh = sh; m_fn = fn;
        m_if_rd = rd;
        m_if_val = alu_f(m_rs_d, m_rt_d, sh, fn);
      end
    end
    m_acc = acc;
    #1;
    check("wb_valid", {31'd0, wb_valid}, {31'd0, m_wb_v});
    check("illegal", {31'd0, illegal}, {31'd0, m_ill});
    check("retired_cnt", {28'd0, retired_cnt}, {28'd0, m_cnt});
    if (m_wb_v) begin
      check("wb_rd", {27'd0, wb_rd}, {27'd0, m_wb_rd});
      check("wb_data", wb_data, m_wb_data);
    end
    check("alu_rs_data", alu_rs_data, m_rs_d);
    check("alu_rt_data", alu_rt_data, m_rt_d);
    check("alu_shamt", {27'd0, alu_shamt}, {27'd0, m_sh});
    check("alu_funct", {26'd0, alu_funct}, {26'd0, m_fn});
  endtask

  // Offer an instruction until accepted (bounded); returns cycles spent stalled
  task automatic issue(input logic [31:0] ins, output int stalls);
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, ins, 1'b1);
      if (m_acc) break;
      stalls++;
    end
    check("issue_accept", {31'd0, m_acc}, 32'd1);
  endtask

  initial begin
    int st, exp_st;
    logic [CNT_W-1:0] cnt_before;
    logic [5:0] fn_tab [5];
    fn_tab[0] = FUNCT_ADD; fn_tab[1] = FUNCT_SUB; fn_tab[2] = FUNCT_SLL;
    fn_tab[3] = FUNCT_OR;  fn_tab[4] = FUNCT_LDK;
`ifdef RTYPE_ISSUE_FORWARD_EN
    exp_st = 0;
`else
    exp_st = 1;
`endif

    // Reset held 3 cycles with an instruction offered
    rst_n = 1'b0; instr_valid = 1'b1; instr = mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, FUNCT_ADD);
    dbg_addr = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_cnt", {28'd0, retired_cnt}, 32'd0);
    check("rst_alu_rs", alu_rs_data, 32'd0);
    check("rst_alu_rt", alu_rt_data, 32'd0);
    check("rst_alu_sh", {27'd0, alu_shamt}, 32'd0);
    check("rst_alu_fn", {26'd0, alu_funct}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      check("rst_dbg", dbg_data, 32'd0);
    end
    model_reset();

    // Preload r1=5, r2=7, then r3 = r1 + r2
    issue(mk(6'd0, 5'd0, 5'd0, 5'd1, 5'd5, FUNCT_LDK), st);
    issue(mk(6'd0, 5'd0, 5'd0, 5'd2, 5'd7, FUNCT_LDK), st);
    issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, FUNCT_ADD), st);
    step(1'b0, 32'd0, 1'b1);
    check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("add_wb_rd", {27'd0, wb_rd}, 32'd3);
    check("add_wb_data", wb_data, 32'd12);

    // Back-to-back dependent: r3 = r1 + r2, then r4 = r3 - r1
    issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, FUNCT_ADD), st);
    issue(mk(6'd0, 5'd3, 5'd1, 5'd4, 5'd0, FUNCT_SUB), st);
    check("dep_stalls", 32'(st), 32'(exp_st));
    step(1'b0, 32'd0, 1'b1);
    check("sub_wb_rd", {27'd0, wb_rd}, 32'd4);
    check("sub_wb_data", wb_data, 32'd7);

    // Write to $0 is reported but discarded
    issue(mk(6'd0, 5'd1, 5'd0, 5'd0, 5'd0, FUNCT_OR), st);
    step(1'b0, 32'd0, 1'b1);
    check("or0_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("or0_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("or0_wb_data", wb_data, 32'd5);
    dbg_addr = 5'd0;
    #1;
    check("or0_dbg", dbg_data, 32'd0);

    // Shift by shamt
    issue(mk(6'd0, 5'd1, 5'd0, 5'd6, 5'd4, FUNCT_SLL), st);
    step(1'b0, 32'd0, 1'b1);
    check("sll_wb_data", wb_data, 32'd80);

    // Illegal opcode: accepted, flagged, dropped
    step(1'b0, 32'd0, 1'b1);
    cnt_before = m_cnt;
    issue(mk(OPC_LW, 5'd1, 5'd2, 5'd3, 5'd0, FUNCT_ADD), st);
    check("ill_pulse", {31'd0, illegal}, 32'd1);
    step(1'b0, 32'd0, 1'b1);
    check("ill_pulse_end", {31'd0, illegal}, 32'd0);
    check("ill_no_wb", {31'd0, wb_valid}, 32'd0);
    check("ill_cnt", {28'd0, retired_cnt}, {28'd0, cnt_before});

    // Reset while an instruction is in EX
    issue(mk(6'd0, 5'd1, 5'd2, 5'd5, 5'd0, FUNCT_ADD), st);
    step(1'b0, 32'd0, 1'b0);
    check("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
    dbg_addr = 5'd5;
    #1;
    check("mid_rst_dbg5", dbg_data, 32'd0);
    step(1'b0, 32'd0, 1'b1);
    check("mid_rst_wb2", {31'd0, wb_valid}, 32'd0);

    // Randomized traffic over a small register window to provoke hazards and counter wrap
    for (int n = 0; n < 600; n++) begin
      bit v, rstn;
      logic [5:0] op, fn;
      v    = ($urandom_range(0, 3) != 0);
      rstn = ($urandom_range(0, 149) != 0);
      op   = ($urandom_range(0, 9) == 0) ? OPC_LW : 6'd0;
      fn   = ($urandom_range(0, 19) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
      step(v, mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom), fn), rstn);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
